// File: rtl/spi_pkg.sv
// Shared types and default opcodes for the framed SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    localparam logic [7:0] SPI_WR_OP = 8'h3C;
    localparam logic [7:0] SPI_RD_OP = 8'h5B;

endpackage

// File: rtl/spi_master_gen_sclk.sv
// SCLK divider: one tick every clk_div+1 clocks while enabled; toggles sclk only when running.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_run,
    input  logic             i_cpol,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_sclk,
    output logic             o_half_stb,
    output logic             o_lead_stb,
    output logic             o_trail_stb
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick      = i_en && (r_cnt == i_div);
    assign o_half_stb  = w_tick;
    assign o_lead_stb  = w_tick && i_run && (o_sclk == i_cpol);
    assign o_trail_stb = w_tick && i_run && (o_sclk != i_cpol);

    // Disabled or not running: sclk parks at the idle level and the divider restarts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            o_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            o_sclk <= i_cpol;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
            if (!i_run)
                o_sclk <= i_cpol;
            else if (w_tick)
                o_sclk <= ~o_sclk;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// Framed SPI master: opcode, address, then len data words, with stalling at word boundaries.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    parameter int LEN_W  = 8,
    parameter logic [DATA_W-1:0] WR_OP = DATA_W'(SPI_WR_OP),
    parameter logic [DATA_W-1:0] RD_OP = DATA_W'(SPI_RD_OP),
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_wr,
    input  logic [CS_W-1:0]   i_cs_sel,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic [DIV_W-1:0]  i_clk_div,
    input  logic [DATA_W-1:0] i_wdat,
    input  logic              i_wdat_vld,
    output logic              o_wdat_rdy,
    output logic [DATA_W-1:0] o_rdat,
    output logic              o_rdat_vld,
    input  logic              i_rdat_rdy,
    output logic              o_busy,
    output logic              o_done,
    output logic [NUM_CS-1:0] o_scsn,
    output logic              o_sclk,
    output logic              o_mosi,
    input  logic              i_miso
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t            r_state;
    mode_t             r_mode;
    logic              r_wr;
    logic [DATA_W-1:0] r_addr;
    logic [DIV_W-1:0]  r_div;
    logic [LEN_W:0]    r_total;
    logic [LEN_W:0]    r_wordIdx;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_rx;

    logic              w_accept;
    logic              w_sclkEn;
    logic              w_sclkRun;
    logic              w_cpol;
    logic              w_half;
    logic              w_lead;
    logic              w_trail;
    logic              w_sample;
    logic              w_shiftOut;
    logic              w_lastBit;
    logic              w_isData;
    logic [LEN_W:0]    w_nextIdx;
    logic              w_nextIsWrData;
    logic [DATA_W-1:0] w_rxNext;
    logic [DATA_W-1:0] w_loadWord;
    logic              w_loadGo;

    assign w_accept  = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start &&
                       (int'(i_cs_sel) < NUM_CS);
    assign w_sclkEn  = (r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD);
    assign w_sclkRun = (r_state == S_SHIFT);
    // Switching the idle level on the accept edge keeps sclk from moving after scsn falls.
    assign w_cpol    = w_accept ? i_cpol : r_mode.cpol;

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (w_sclkEn),
        .i_run       (w_sclkRun),
        .i_cpol      (w_cpol),
        .i_div       (r_div),
        .o_sclk      (o_sclk),
        .o_half_stb  (w_half),
        .o_lead_stb  (w_lead),
        .o_trail_stb (w_trail)
    );

    assign w_sample       = r_mode.cpha ? w_trail : w_lead;
    assign w_shiftOut     = r_mode.cpha ? w_lead : w_trail;
    assign w_rxNext       = w_sample ? {r_rx[DATA_W-2:0], i_miso} : r_rx;
    assign w_lastBit      = w_trail && (r_bitCnt == LAST_BIT);
    assign w_isData       = (r_wordIdx >= (LEN_W+1)'(2));
    assign w_nextIdx      = r_wordIdx + (LEN_W+1)'(1);
    assign w_nextIsWrData = r_wr && (w_nextIdx >= (LEN_W+1)'(2)) && (w_nextIdx != r_total);

    always_comb begin
        w_loadWord = '0;
        w_loadGo   = 1'b0;
        if (r_wordIdx == '0) begin
            w_loadWord = r_wr ? WR_OP : RD_OP;
            w_loadGo   = 1'b1;
        end else if (r_wordIdx == (LEN_W+1)'(1)) begin
            w_loadWord = r_addr;
            w_loadGo   = 1'b1;
        end else if (r_wr) begin
            w_loadWord = i_wdat;
            w_loadGo   = o_wdat_rdy && i_wdat_vld;
        end else begin
            w_loadGo   = !o_rdat_vld || i_rdat_rdy;
        end
    end

    // Transfer sequencer; every pin-facing output is a register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_mode     <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_div      <= '0;
            r_total    <= '0;
            r_wordIdx  <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_rx       <= '0;
            o_wdat_rdy <= 1'b0;
            o_rdat     <= '0;
            o_rdat_vld <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_scsn     <= '1;
            o_mosi     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (o_rdat_vld && i_rdat_rdy)
                o_rdat_vld <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        r_wr      <= i_wr;
                        r_mode    <= '{cpol: i_cpol, cpha: i_cpha};
                        r_addr    <= i_addr;
                        r_div     <= i_clk_div;
                        r_total   <= {1'b0, i_len} + (LEN_W+1)'(2);
                        r_wordIdx <= '0;
                        r_bitCnt  <= '0;
                        o_busy    <= 1'b1;
                        o_scsn    <= ~(NUM_CS'(1) << i_cs_sel);
                        r_state   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_half)
                        r_state <= S_LOAD;
                end

                S_LOAD: begin
                    if (w_loadGo) begin
                        o_wdat_rdy <= 1'b0;
                        if (r_mode.cpha) begin
                            r_shift <= w_loadWord;
                        end else begin
                            r_shift <= w_loadWord << 1;
                            o_mosi  <= w_loadWord[DATA_W-1];
                        end
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (w_sample)
                        r_rx <= w_rxNext;
                    if (w_shiftOut) begin
                        o_mosi  <= r_shift[DATA_W-1];
                        r_shift <= r_shift << 1;
                    end
                    if (w_trail)
                        r_bitCnt <= r_bitCnt + BIT_W'(1);
                    if (w_lastBit) begin
                        r_bitCnt  <= '0;
                        r_wordIdx <= w_nextIdx;
                        if (w_isData && !r_wr) begin
                            o_rdat     <= w_rxNext;
                            o_rdat_vld <= 1'b1;
                        end
                        o_wdat_rdy <= w_nextIsWrData;
                        r_state    <= (w_nextIdx == r_total) ? S_HOLD : S_LOAD;
                    end
                end

                S_HOLD: begin
                    if (w_half) begin
                        o_scsn  <= '1;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
Parametrised, multi-chip-select SPI master that frames each transfer as an opcode word, an address word, then `len` data words.
- Next generation of the team's fixed-mode byte SPI master.
- Adds a programmable SCLK divider, all four CPOL/CPHA modes, NUM_CS selects, and valid/ready streaming for write and read data, with word-boundary stalling.
- Sits between a register/DMA front-end and the external SPI pins.

Parameters:
DATA_W, 8, bits per SPI word (opcode, address and data words are all DATA_W)
NUM_CS, 4, number of active-low chip selects
DIV_W, 8, width of clk_div
LEN_W, 8, width of len
WR_OP, 8'h3C, opcode for write transfers (DATA_W wide)
RD_OP, 8'h5B, opcode for read transfers (DATA_W wide)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, asynchronous, active-high
start  in  1  single-cycle request; accepted only when busy=0
wr  in  1  1=write transfer, 0=read transfer; sampled at start
cs_sel  in  $clog2(NUM_CS)  chip-select index; sampled at start
addr  in  DATA_W  address word; sampled at start
len  in  LEN_W  number of data words; sampled at start
cpol  in  1  SCLK idle level; sampled at start
cpha  in  1  phase select; sampled at start
clk_div  in  DIV_W  SCLK half-period = clk_div+1 clk cycles; sampled at start
wdat  in  DATA_W  write data word
wdat_vld  in  1  write data valid
wdat_rdy  out  1  master requests next write word
rdat  out  DATA_W  read data word
rdat_vld  out  1  read word valid; held until rdat_rdy
rdat_rdy  in  1  consumer ready
busy  out  1  transfer in progress
done  out  1  single-cycle end-of-transfer pulse
scsn  out  NUM_CS  chip selects, active low
sclk  out  1  SPI clock
mosi  out  1  master out
miso  in  1  master in

Behaviour:
- Reset values: scsn all 1, sclk 0, mosi 0, wdat_rdy 0, rdat 0, rdat_vld 0, busy 0, done 0; FSM goes to IDLE.
- Reset mid-transfer aborts immediately: scsn deasserts asynchronously and no done pulse is produced.
- start handling:
  - start with busy=1 is ignored.
  - start with cs_sel>=NUM_CS is ignored (no busy, no done).
- Transfer order: all words MSB first. Word sequence is opcode (WR_OP or RD_OP), then addr, then len data words.
- FSM states: IDLE -> SETUP -> LOAD -> SHIFT -> (LOAD | HOLD) -> DONE -> IDLE.
- IDLE:
  - sclk = last cpol; scsn all high.
  - On an accepted start: register the config, then next cycle busy=1 and scsn[cs_sel]=0.
- SETUP: sclk held at cpol for one half-period.
- LOAD:
  - Header words load internally with no wait.
  - Write data word: wdat_rdy=1 until wdat_vld; the handshake cycle loads the shifter.
  - Read data word: wait until rdat_vld=0, or rdat_rdy=1 in the same cycle; during read data words mosi shifts zeros.
  - While waiting, sclk stays at cpol and scsn stays low.
  - LOAD costs at least one clk cycle per word (inter-word gap).
- SHIFT: DATA_W SCLK periods. Leading edge = sclk leaving cpol; trailing edge = return to cpol.
  - cpha=0: mosi presents the MSB on entry to SHIFT; sample miso on the leading edge; shift mosi on the trailing edge.
  - cpha=1: shift mosi on the leading edge; sample on the trailing edge.
  - After the last bit, go to LOAD if words remain, else HOLD.
- Read capture: in read transfers, data words only (header bits discarded). The final sample of each word is written to rdat with rdat_vld=1 on the next clk.
- HOLD: one half-period with sclk=cpol, then scsn all high.
- DONE:
  - done=1 for one cycle; busy falls in the same cycle.
  - Back-to-back start is accepted in the following cycle.
- len=0: header only; no wdat_rdy, no rdat_vld.
- Counters:
  - Divider counter: DIV_W bits.
  - Bit counter: $clog2(DATA_W) bits.
  - Word counter: LEN_W+1 bits, counting len+2 words; it must not wrap for len = 2^LEN_W-1.

Decomposition:
- Package spi_pkg: FSM state enum, mode struct {cpol, cpha}, default WR_OP/RD_OP constants.
- Sub-module spi_sclk_gen:
  - Owns the divider.
  - Produces sclk plus single-cycle lead_stb and trail_stb.
  - Enable input gates it; when disabled it holds sclk=cpol.

Test Plan:
- Mode 0 write: DATA_W=8, clk_div=0, addr=0x12, len=2, wdat 0xA5 then 0x3C, both always valid -> mosi 3C,12,A5,3C MSB-first sampled on rising sclk; 32 sclk periods; scsn[cs_sel] low throughout; one done pulse.
- Mode 3 read: clk_div=3, len=2, slave model drives 0x81 then 0x7E -> rdat_vld twice with rdat 0x81, 0x7E; mosi all zeros after the header; sclk half-period 4 clk.
- Write stall: wdat_vld low for 20 cycles before the 2nd data word -> sclk frozen at cpol, scsn low, wdat_rdy high; resumes and completes with correct data.
- Read backpressure: rdat_rdy=0 after the 1st word, len=3 -> no SCLK edges until rdat_rdy rises; all 3 words delivered in order, none lost.
- Reset mid-word: assert rst in the 5th bit of the addr word -> scsn all 1 immediately, no done; a subsequent len=1 write completes normally.
- Protocol corners: start while busy ignored; cs_sel=NUM_CS ignored; len=0 write -> 16 sclk periods, no wdat_rdy, done.
